// File: rtl/pwm_synth_pkg.sv
// Shared constants and helpers for the PWM synthesiser.
package pwm_synth_pkg;

  // Default configuration of the synthesiser.
  localparam int NUM_VOICES_DEF          = 3;
  localparam int DIV_W_DEF               = 12;
  localparam int VOL_W_DEF               = 4;
  localparam int PWM_W_DEF               = 8;
  localparam int GAIN_SH_DEF             = 2;
  localparam int CROTCHET_W_DEF          = 7;
  localparam int FRAMES_PER_CROTCHET_DEF = 24414;

  // Mixer width that can hold the sum of every voice at full volume.
  localparam int MIX_W     = VOL_W_DEF + $clog2(NUM_VOICES_DEF + 1);
  // Largest sample value, also the counter value on the frame-boundary cycle.
  localparam int FRAME_MAX = (1 << PWM_W_DEF) - 1;

  // Clamp a value to an upper limit.
  function automatic logic [31:0] saturate(input logic [31:0] value,
                                           input logic [31:0] limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/pwm_synth_if.sv
// Voice configuration port of the PWM synthesiser.
//
// Handshake: a request transfers on every rising clock edge where
// cfg_valid && cfg_ready. The master holds cfg_voice/cfg_period/cfg_volume
// stable while cfg_valid is high and cfg_ready is low; cfg_ready does not
// depend on cfg_valid.
interface pwm_synth_if #(
  parameter int VOICE_W = 2,
  parameter int DIV_W   = 12,
  parameter int VOL_W   = 4
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [VOICE_W-1:0] cfg_voice;
  logic [DIV_W-1:0]   cfg_period;
  logic [VOL_W-1:0]   cfg_volume;

  modport master (output cfg_valid, cfg_voice, cfg_period, cfg_volume,
                  input  cfg_ready);
  modport slave  (input  cfg_valid, cfg_voice, cfg_period, cfg_volume,
                  output cfg_ready);
endinterface

// File: rtl/pwm_voice.sv
// One square-wave voice: frame-rate divider plus volume-gated level.
module pwm_voice #(
  parameter int DIV_W = 12,
  parameter int VOL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] period_i,
  input  logic [VOL_W-1:0] volume_i,
  output logic [VOL_W-1:0] level_o
);
  logic [DIV_W-1:0] period_q, period_d;
  logic [VOL_W-1:0] volume_q, volume_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             sq_q, sq_d;

  // Voice step on frame boundaries: reload restarts the wave high, period 0 mutes.
  always_comb begin
    period_d = period_q;
    volume_d = volume_q;
    cnt_d    = cnt_q;
    sq_d     = sq_q;
    if (step_i) begin
      if (load_i) begin
        period_d = period_i;
        volume_d = volume_i;
        cnt_d    = '0;
        sq_d     = 1'b1;
      end else if (period_q == '0) begin
        cnt_d = '0;
        sq_d  = 1'b0;
      end else if (cnt_q == period_q - DIV_W'(1)) begin
        cnt_d = '0;
        sq_d  = ~sq_q;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  // Voice state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q <= '0;
      volume_q <= '0;
      cnt_q    <= '0;
      sq_q     <= 1'b0;
    end else begin
      period_q <= period_d;
      volume_q <= volume_d;
      cnt_q    <= cnt_d;
      sq_q     <= sq_d;
    end
  end

  assign level_o = sq_q ? volume_q : '0;

endmodule

// File: rtl/pwm_synth.sv
// Multi-voice PWM audio generator with config holding register and tempo counter.
module pwm_synth
  import pwm_synth_pkg::*;
#(
  parameter int NUM_VOICES          = NUM_VOICES_DEF,
  parameter int DIV_W               = DIV_W_DEF,
  parameter int VOL_W               = VOL_W_DEF,
  parameter int PWM_W               = PWM_W_DEF,
  parameter int GAIN_SH             = GAIN_SH_DEF,
  parameter int CROTCHET_W          = CROTCHET_W_DEF,
  parameter int FRAMES_PER_CROTCHET = FRAMES_PER_CROTCHET_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pwm_synth_if.slave            cfg,
  output logic                  pwm,
  output logic [PWM_W-1:0]      sample,
  output logic                  frame_pulse,
  output logic [CROTCHET_W-1:0] crotchet,
  output logic                  crotchet_pulse
);
  localparam int VOICE_W   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int MIX_W_P   = VOL_W + $clog2(NUM_VOICES + 1);
  localparam int FRAME_TOP = (1 << PWM_W) - 1;
  localparam int FC_W      = (FRAMES_PER_CROTCHET > 1) ? $clog2(FRAMES_PER_CROTCHET) : 1;

  logic [PWM_W-1:0]      pwm_cnt_q, pwm_cnt_d;
  logic [PWM_W-1:0]      sample_q, sample_d;
  logic                  pwm_q, pwm_d;
  logic                  pend_q, pend_d;
  logic [VOICE_W-1:0]    pend_voice_q, pend_voice_d;
  logic [DIV_W-1:0]      pend_period_q, pend_period_d;
  logic [VOL_W-1:0]      pend_volume_q, pend_volume_d;
  logic [FC_W-1:0]       frame_cnt_q, frame_cnt_d;
  logic [CROTCHET_W-1:0] crotchet_q, crotchet_d;
  logic                  cpulse_q, cpulse_d;
  logic                  boundary;
  logic                  cfg_accept;
  logic [VOL_W-1:0]      level_w [NUM_VOICES];
  logic [MIX_W_P-1:0]    mix;

  assign boundary    = (pwm_cnt_q == PWM_W'(FRAME_TOP));
  assign cfg_accept  = cfg.cfg_valid && !pend_q;
  assign cfg.cfg_ready = !pend_q;

  // Holding register: drains on a boundary, refills on a transfer (never both at once).
  always_comb begin
    pend_d        = pend_q;
    pend_voice_d  = pend_voice_q;
    pend_period_d = pend_period_q;
    pend_volume_d = pend_volume_q;
    if (boundary) pend_d = 1'b0;
    if (cfg_accept) begin
      pend_d        = 1'b1;
      pend_voice_d  = cfg.cfg_voice;
      pend_period_d = cfg.cfg_period;
      pend_volume_d = cfg.cfg_volume;
    end
  end

  // Voice bank; an out-of-range voice index matches no voice and is dropped.
  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    pwm_voice #(.DIV_W(DIV_W), .VOL_W(VOL_W)) u_voice (
      .clk      (clk),
      .rst_n    (rst_n),
      .step_i   (boundary),
      .load_i   (pend_q && (pend_voice_q == VOICE_W'(v))),
      .period_i (pend_period_q),
      .volume_i (pend_volume_q),
      .level_o  (level_w[v])
    );
  end

  // Full-width sum of voice levels (uses pre-step voice state).
  always_comb begin
    mix = '0;
    for (int v = 0; v < NUM_VOICES; v++) mix = mix + MIX_W_P'(level_w[v]);
  end

  // Frame counter, saturated sample capture and registered PWM comparator.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
    sample_d  = sample_q;
    if (boundary) sample_d = PWM_W'(saturate(32'(mix) << GAIN_SH, 32'(FRAME_TOP)));
    pwm_d = (pwm_cnt_q < sample_q);
  end

  // Tempo: count boundaries, bump the beat index at the terminal frame.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    crotchet_d  = crotchet_q;
    cpulse_d    = 1'b0;
    if (boundary) begin
      if (frame_cnt_q == FC_W'(FRAMES_PER_CROTCHET - 1)) begin
        frame_cnt_d = '0;
        crotchet_d  = crotchet_q + CROTCHET_W'(1);
        cpulse_d    = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + FC_W'(1);
      end
    end
  end

  // All top-level state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q     <= '0;
      sample_q      <= '0;
      pwm_q         <= 1'b0;
      pend_q        <= 1'b0;
      pend_voice_q  <= '0;
      pend_period_q <= '0;
      pend_volume_q <= '0;
      frame_cnt_q   <= '0;
      crotchet_q    <= '0;
      cpulse_q      <= 1'b0;
    end else begin
      pwm_cnt_q     <= pwm_cnt_d;
      sample_q      <= sample_d;
      pwm_q         <= pwm_d;
      pend_q        <= pend_d;
      pend_voice_q  <= pend_voice_d;
      pend_period_q <= pend_period_d;
      pend_volume_q <= pend_volume_d;
      frame_cnt_q   <= frame_cnt_d;
      crotchet_q    <= crotchet_d;
      cpulse_q      <= cpulse_d;
    end
  end

  assign pwm            = pwm_q;
  assign sample         = sample_q;
  assign frame_pulse    = boundary;
  assign crotchet       = crotchet_q;
  assign crotchet_pulse = cpulse_q;

endmodule

// File: tb/tb_pwm_synth.sv
// Directed bench for pwm_synth: instance A (gain 2, short tempo) and B (gain 3).
module tb_pwm_synth;
  localparam int VW = 2;
  localparam int DW = 12;
  localparam int LW = 4;
  localparam int PW = 8;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pwm_synth_if #(.VOICE_W(VW), .DIV_W(DW), .VOL_W(LW)) cfg_a ();
  pwm_synth_if #(.VOICE_W(VW), .DIV_W(DW), .VOL_W(LW)) cfg_b ();

  logic          pwm_a, fp_a, cp_a;
  logic [PW-1:0] sample_a;
  logic [1:0]    crot_a;
  logic          pwm_b, fp_b, cp_b;
  logic [PW-1:0] sample_b;
  logic [6:0]    crot_b;

  pwm_synth #(.NUM_VOICES(3), .DIV_W(DW), .VOL_W(LW), .PWM_W(PW), .GAIN_SH(2),
              .CROTCHET_W(2), .FRAMES_PER_CROTCHET(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .cfg(cfg_a), .pwm(pwm_a), .sample(sample_a),
    .frame_pulse(fp_a), .crotchet(crot_a), .crotchet_pulse(cp_a));

  pwm_synth #(.NUM_VOICES(3), .DIV_W(DW), .VOL_W(LW), .PWM_W(PW), .GAIN_SH(3),
              .CROTCHET_W(7), .FRAMES_PER_CROTCHET(24414)) dut_b (
    .clk(clk), .rst_n(rst_n), .cfg(cfg_b), .pwm(pwm_b), .sample(sample_b),
    .frame_pulse(fp_b), .crotchet(crot_b), .crotchet_pulse(cp_b));

  int n_checks = 0;
  int n_pass   = 0;

  // Driver tasks
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Leaves the bench at the negedge of the first cycle after a frame boundary.
  task automatic to_frame_start();
    int n = 0;
    @(negedge clk);
    while (fp_a !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (fp_a !== 1'b1) begin
      n_checks++;
      $display("FAIL frame_wait: frame_pulse=%b after %0d cycles, required 1", fp_a, n);
    end
    @(negedge clk);
  endtask

  task automatic cfg_write(input bit use_b, input logic [VW-1:0] voice,
                           input logic [DW-1:0] period, input logic [LW-1:0] vol);
    int n = 0;
    if (use_b) begin
      cfg_b.cfg_valid = 1'b1; cfg_b.cfg_voice = voice;
      cfg_b.cfg_period = period; cfg_b.cfg_volume = vol;
    end else begin
      cfg_a.cfg_valid = 1'b1; cfg_a.cfg_voice = voice;
      cfg_a.cfg_period = period; cfg_a.cfg_volume = vol;
    end
    while (((use_b ? cfg_b.cfg_ready : cfg_a.cfg_ready) !== 1'b1) && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) begin
      n_checks++;
      $display("FAIL cfg_wait: cfg_ready stayed low for %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
    cfg_a.cfg_valid = 1'b0;
    cfg_b.cfg_valid = 1'b0;
  endtask

  // Counts pwm high cycles of the frame that starts at the current negedge.
  task automatic count_pwm(input bit use_b, output int cnt);
    cnt = 0;
    repeat (256) begin
      @(negedge clk);
      if ((use_b ? pwm_b : pwm_a) === 1'b1) cnt++;
    end
  endtask

  // Scenario tasks
  task automatic test_reset();
    to_frame_start();
    repeat (20) @(negedge clk);
    cfg_write(1'b0, 2'd0, 12'd1, 4'd15);
    @(negedge clk);
    n_checks++; if (cfg_a.cfg_ready !== 1'b0) $display("FAIL reset_pend_ready: got %b want 0", cfg_a.cfg_ready); else n_pass++;
    repeat (60) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (pwm_a !== 1'b0) $display("FAIL reset_pwm: got %b want 0", pwm_a); else n_pass++;
    n_checks++; if (sample_a !== 8'd0) $display("FAIL reset_sample: got %0d want 0", sample_a); else n_pass++;
    n_checks++; if (fp_a !== 1'b0) $display("FAIL reset_frame_pulse: got %b want 0", fp_a); else n_pass++;
    n_checks++; if (crot_a !== 2'd0) $display("FAIL reset_crotchet: got %0d want 0", crot_a); else n_pass++;
    n_checks++; if (cp_a !== 1'b0) $display("FAIL reset_crotchet_pulse: got %b want 0", cp_a); else n_pass++;
    n_checks++; if (cfg_a.cfg_ready !== 1'b1) $display("FAIL reset_cfg_ready: got %b want 1", cfg_a.cfg_ready); else n_pass++;
    n_checks++; if (sample_b !== 8'd0) $display("FAIL reset_sample_b: got %0d want 0", sample_b); else n_pass++;
    n_checks++; if (crot_b !== 7'd0) $display("FAIL reset_crotchet_b: got %0d want 0", crot_b); else n_pass++;
    for (int k = 0; k < 10; k++) begin
      to_frame_start();
      n_checks++; if (sample_a !== 8'd0) $display("FAIL reset_quiet frame %0d: got %0d want 0", k, sample_a); else n_pass++;
    end
  endtask

  task automatic test_single_voice();
    int exp_s[8] = '{60, 60, 0, 0, 60, 60, 0, 0};
    int c;
    apply_reset();
    to_frame_start();
    cfg_write(1'b0, 2'd0, 12'd2, 4'd15);
    to_frame_start();
    n_checks++; if (sample_a !== 8'd0) $display("FAIL sv_first: got %0d want 0", sample_a); else n_pass++;
    count_pwm(1'b0, c);
    for (int k = 0; k < 8; k++) begin
      n_checks++; if (sample_a !== 8'(exp_s[k])) $display("FAIL sv_sample frame %0d: got %0d want %0d", k, sample_a, exp_s[k]); else n_pass++;
      count_pwm(1'b0, c);
      n_checks++; if (c !== exp_s[k]) $display("FAIL sv_pwm_high frame %0d: got %0d want %0d", k, c, exp_s[k]); else n_pass++;
    end
  endtask

  task automatic test_saturation();
    int exp_s[6] = '{0, 255, 0, 255, 0, 255};
    int c;
    apply_reset();
    to_frame_start();
    cfg_write(1'b1, 2'd0, 12'd1, 4'd15);
    to_frame_start(); to_frame_start();
    cfg_write(1'b1, 2'd1, 12'd1, 4'd15);
    to_frame_start(); to_frame_start();
    cfg_write(1'b1, 2'd2, 12'd1, 4'd15);
    to_frame_start();
    for (int k = 0; k < 6; k++) begin
      n_checks++; if (sample_b !== 8'(exp_s[k])) $display("FAIL sat_sample frame %0d: got %0d want %0d", k, sample_b, exp_s[k]); else n_pass++;
      count_pwm(1'b1, c);
      n_checks++; if (c !== exp_s[k]) $display("FAIL sat_pwm_high frame %0d: got %0d want %0d", k, c, exp_s[k]); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    logic last_fp = 1'b0;
    apply_reset();
    to_frame_start();
    cfg_write(1'b0, 2'd0, 12'd3, 4'd5);
    @(negedge clk);
    cfg_a.cfg_valid = 1'b1; cfg_a.cfg_voice = 2'd1;
    cfg_a.cfg_period = 12'd3; cfg_a.cfg_volume = 4'd7;
    n_checks++; if (cfg_a.cfg_ready !== 1'b0) $display("FAIL b2b_ready_low: got %b want 0", cfg_a.cfg_ready); else n_pass++;
    while (cfg_a.cfg_ready !== 1'b1 && n < 600) begin
      last_fp = fp_a;
      @(negedge clk);
      n++;
    end
    n_checks++; if (n !== 255) $display("FAIL b2b_wait_cycles: got %0d want 255", n); else n_pass++;
    n_checks++; if (last_fp !== 1'b1) $display("FAIL b2b_ready_after_boundary: got %b want 1", last_fp); else n_pass++;
    @(posedge clk);
    #1;
    cfg_a.cfg_valid = 1'b0;
    n_checks++; if (sample_a !== 8'd0) $display("FAIL b2b_sample_b1: got %0d want 0", sample_a); else n_pass++;
    to_frame_start();
    n_checks++; if (sample_a !== 8'd20) $display("FAIL b2b_sample_b2: got %0d want 20", sample_a); else n_pass++;
    to_frame_start();
    n_checks++; if (sample_a !== 8'd48) $display("FAIL b2b_sample_b3: got %0d want 48", sample_a); else n_pass++;
  endtask

  task automatic test_discard();
    apply_reset();
    to_frame_start();
    cfg_write(1'b0, 2'd3, 12'd1, 4'd15);
    @(negedge clk);
    n_checks++; if (cfg_a.cfg_ready !== 1'b0) $display("FAIL discard_accepted: got %b want 0", cfg_a.cfg_ready); else n_pass++;
    to_frame_start();
    n_checks++; if (cfg_a.cfg_ready !== 1'b1) $display("FAIL discard_drained: got %b want 1", cfg_a.cfg_ready); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      to_frame_start();
      n_checks++; if (sample_a !== 8'd0) $display("FAIL discard_quiet frame %0d: got %0d want 0", k, sample_a); else n_pass++;
    end
  endtask

  task automatic test_mute();
    int exp_s[4] = '{40, 40, 0, 0};
    apply_reset();
    to_frame_start();
    cfg_write(1'b0, 2'd0, 12'd4, 4'd10);
    to_frame_start();
    to_frame_start();
    n_checks++; if (sample_a !== 8'd40) $display("FAIL mute_tone: got %0d want 40", sample_a); else n_pass++;
    cfg_write(1'b0, 2'd0, 12'd0, 4'd10);
    for (int k = 0; k < 4; k++) begin
      to_frame_start();
      n_checks++; if (sample_a !== 8'(exp_s[k])) $display("FAIL mute_sample frame %0d: got %0d want %0d", k, sample_a, exp_s[k]); else n_pass++;
    end
  endtask

  task automatic test_tempo();
    int n = 0;
    int prev = 0;
    int waited;
    logic [1:0] exp_c;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      waited = 0;
      while (cp_a !== 1'b1 && waited < 1100) begin
        @(negedge clk);
        n++;
        waited++;
      end
      exp_c = 2'(k + 1);
      n_checks++; if (n - prev !== 1024) $display("FAIL tempo_interval beat %0d: got %0d want 1024", k, n - prev); else n_pass++;
      n_checks++; if (crot_a !== exp_c) $display("FAIL tempo_crotchet beat %0d: got %0d want %0d", k, crot_a, exp_c); else n_pass++;
      prev = n;
      @(negedge clk);
      n++;
      n_checks++; if (cp_a !== 1'b0) $display("FAIL tempo_pulse_width beat %0d: got %b want 0", k, cp_a); else n_pass++;
    end
  endtask

  // Watchdog
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Main sequence and final report
  initial begin
    cfg_a.cfg_valid = 1'b0; cfg_a.cfg_voice = '0; cfg_a.cfg_period = '0; cfg_a.cfg_volume = '0;
    cfg_b.cfg_valid = 1'b0; cfg_b.cfg_voice = '0; cfg_b.cfg_period = '0; cfg_b.cfg_volume = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_single_voice();
    test_saturation();
    test_back_to_back();
    test_discard();
    test_mute();
    test_tempo();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
